// File: rtl/soc_event_arbiter.sv
// soc_event_arbiter: latches event pulses as pending flags and pushes one event ID per valid/grant handshake.
// Round-robin by default; define SOC_EVT_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module soc_event_arbiter #(
   parameter int NB_SOURCES   = 32,
   parameter int EVT_ID_WIDTH = 8,
   parameter int ID_BASE      = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NB_SOURCES-1:0]   events_i,
   output logic                    evt_valid_o,
   input  logic                    evt_grant_i,
   output logic [EVT_ID_WIDTH-1:0] evt_data_o,
   output logic                    err_overflow_o,
   output logic [NB_SOURCES-1:0]   pending_o
);
   localparam int IW = (NB_SOURCES > 1) ? $clog2(NB_SOURCES) : 1;
   logic [NB_SOURCES-1:0]   r_pending, w_cand, w_sel;
   logic                    r_valid, r_ovf, w_load, w_found;
   logic [EVT_ID_WIDTH-1:0] r_data, w_id;
   logic [IW-1:0]           w_idx;
   assign w_cand = r_pending | events_i;
   assign w_load = ~r_valid | evt_grant_i;
   assign w_sel  = (w_load & w_found) ? (NB_SOURCES'(1) << w_idx) : '0;
   assign w_id   = EVT_ID_WIDTH'(ID_BASE) + EVT_ID_WIDTH'(w_idx);
`ifdef SOC_EVT_ARB_FIXED_PRIO_EN
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = NB_SOURCES - 1; k >= 0; k--)
         if (w_cand[k]) begin
            w_found = 1'b1;
            w_idx   = IW'(k);
         end
   end
`else
   logic [IW-1:0] r_rr;
   // Scan downward so the candidate closest above r_rr is the last (winning) assignment.
   always_comb begin
      int j;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = NB_SOURCES - 1; k >= 0; k--) begin
         j = int'(r_rr) + k;
         j = (j >= NB_SOURCES) ? j - NB_SOURCES : j;
         if (w_cand[j]) begin
            w_found = 1'b1;
            w_idx   = IW'(j);
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni)
         r_rr <= '0;
      else if (w_load && w_found)
         r_rr <= (w_idx == IW'(NB_SOURCES - 1)) ? '0 : w_idx + IW'(1);
`endif
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_pending <= '0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_pending <= (w_sel & r_pending & events_i) | (~w_sel & w_cand);
         r_ovf     <= |(r_pending & events_i & ~w_sel);
         if (w_load) begin
            r_valid <= w_found;
            if (w_found)
               r_data <= w_id;
         end
      end
   assign evt_valid_o    = r_valid;
   assign evt_data_o     = r_data;
   assign err_overflow_o = r_ovf;
   assign pending_o      = r_pending;
endmodule

// File: tb/tb_soc_event_arbiter.sv
// tb_soc_event_arbiter: scoreboard bench; expected IDs queued at stimulus time, popped on each handshake.
module tb_soc_event_arbiter;
   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] events = '0, events2 = '0, pending, pending2;
   logic        grant = 1'b0, valid, ovf, valid2, ovf2;
   logic [7:0]  data, data2;
   int          n_chk = 0, n_err = 0, n_ovf = 0, ovf0;
   int          q[$];

   soc_event_arbiter dut (
      .clk_i(clk), .rst_ni(rst_ni), .events_i(events), .evt_valid_o(valid),
      .evt_grant_i(grant), .evt_data_o(data), .err_overflow_o(ovf), .pending_o(pending)
   );
   soc_event_arbiter #(.ID_BASE(250)) dut_b (
      .clk_i(clk), .rst_ni(rst_ni), .events_i(events2), .evt_valid_o(valid2),
      .evt_grant_i(1'b1), .evt_data_o(data2), .err_overflow_o(ovf2), .pending_o(pending2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      events = '0;
      grant  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain", q.size(), 0);
      repeat (2) tick();
   endtask

   always @(negedge clk)
      if (rst_ni) begin
         if (ovf) n_ovf++;
         if (valid && grant) begin
            if (q.size() != 0) chk("id", data, q.pop_front());
            else chk("extra_xfer", 1, 0);
         end
      end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      // 1: reset values, single pulse latency
      do_reset();
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_pend", pending, 0);
      chk("rst_ovf", ovf, 0);
      grant = 1'b1;
      events = 32'd1 << 5;
      q.push_back(5);
      tick();
      chk("t1_valid", valid, 1);
      chk("t1_data", data, 5);
      events = '0;
      tick();
      chk("t1_idle", valid, 0);
      chk("t1_pend", pending, 0);
      // 2: backpressure holds data stable
      do_reset();
      ovf0 = n_ovf;
      events = (32'd1 << 3) | (32'd1 << 7);
      q.push_back(3);
      q.push_back(7);
      tick();
      events = '0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_hold_v", valid, 1);
         chk("t2_hold_d", data, 3);
         tick();
      end
      grant = 1'b1;
      wait_drain(20);
      chk("t2_ovf", n_ovf - ovf0, 0);
      // 3: round-robin order with wrap
      do_reset();
      grant = 1'b1;
      q.push_back(0);
      q.push_back(1);
      q.push_back(31);
      q.push_back(0);
      events = 32'h8000_0003;
      tick();
      events = 32'd1;
      tick();
      events = '0;
      wait_drain(20);
      chk("t3_pend", pending, 0);
      // 4: overflow on an already-pending source
      do_reset();
      ovf0 = n_ovf;
      events = 32'd1;
      q.push_back(0);
      tick();
      events = 32'd1 << 2;
      chk("t4_pend_reg", pending, 0);
      tick();
      tick();
      events = '0;
      q.push_back(2);
      chk("t4_pend", pending, 32'd1 << 2);
      tick();
      grant = 1'b1;
      wait_drain(20);
      chk("t4_ovf", n_ovf - ovf0, 1);
      // 5: consume and re-arrive in the same cycle
      do_reset();
      ovf0 = n_ovf;
      events = 32'd1;
      q.push_back(0);
      tick();
      events = 32'd1 << 4;
      tick();
      grant = 1'b1;
      q.push_back(4);
      q.push_back(4);
      tick();
      events = '0;
      wait_drain(20);
      chk("t5_ovf", n_ovf - ovf0, 0);
      // 6a: ID wraps modulo 2^8
      events2 = 32'd1 << 10;
      tick();
      events2 = '0;
      chk("t6_valid_b", valid2, 1);
      chk("t6_data_b", data2, 4);
      // 6b: async reset mid-transfer discards everything
      do_reset();
      events = 32'h1E;
      tick();
      events = '0;
      chk("t6_valid", valid, 1);
      chk("t6_data", data, 1);
      chk("t6_pend", pending, 32'h1C);
      #3 rst_ni = 1'b0;
      #1;
      chk("t6_rst_v", valid, 0);
      chk("t6_rst_d", data, 0);
      chk("t6_rst_p", pending, 0);
      chk("t6_rst_o", ovf, 0);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      grant = 1'b1;
      repeat (10) tick();
      chk("t6_after_v", valid, 0);
      chk("t6_after_p", pending, 0);
      chk("t6_queue", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/soc_event_arbiter.md
Name: soc_event_arbiter

Overview:
Upstream feeder for the SoC interrupt controller's event-ID FIFO. Collects single-cycle event pulses from up to NB_SOURCES peripheral sources and latches each one as a pending flag. Pending sources are arbitrated round-robin, and one event ID per handshake is pushed on a valid/grant interface. That interface connects directly to the controller's event_fifo_valid_i / event_fifo_fulln_o / event_fifo_data_i.

Parameters:
NB_SOURCES, 32, number of event sources (1..256)
EVT_ID_WIDTH, 8, width of emitted event ID
ID_BASE, 0, offset added to source index to form the event ID

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
events_i  input  NB_SOURCES  event pulses; bit i high for one cycle = one event on source i
evt_valid_o  output  1  event ID available
evt_grant_i  input  1  consumer accepts (FIFO not full); transfer = evt_valid_o & evt_grant_i
evt_data_o  output  EVT_ID_WIDTH  event ID = (ID_BASE + source index) mod 2^EVT_ID_WIDTH
err_overflow_o  output  1  one-cycle pulse: event lost on an already-pending source
pending_o  output  NB_SOURCES  current pending flags, for debug/status

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values (asynchronous, any time, including mid-transfer):
  - pending_q = 0, evt_valid_o = 0, evt_data_o = 0, err_overflow_o = 0, rr pointer = 0.
  - Pending events are discarded.
- Candidate vector: cand = pending_q | events_i. A new pulse is eligible in the same cycle it arrives.
- Load condition: load = ~evt_valid_o | evt_grant_i (output register empty, or draining this cycle).
- Selection, when load and cand != 0:
  - Pick the first set bit of cand searching upward from rr_q, wrapping from NB_SOURCES-1 to 0.
  - sel = one-hot of that index.
  - On the edge: evt_valid_o <= 1, evt_data_o <= ID_BASE + index (truncated to EVT_ID_WIDTH), rr_q <= (index+1) mod NB_SOURCES.
- Empty case: when load and cand == 0, evt_valid_o <= 0; evt_data_o and rr_q hold.
- Stall: when evt_valid_o & ~evt_grant_i, evt_data_o and evt_valid_o hold stable. No new selection; sel = 0.
- Pending update, per bit i:
  - sel[i] = 1: pending_next = pending_q[i] & events_i[i]. The consumed event is cleared; a second simultaneous event is retained.
  - otherwise: pending_next = pending_q[i] | events_i[i].
- Overflow: err_overflow_o <= |(pending_q & events_i & ~sel).
  - Registered, one-cycle pulse.
  - The extra event is dropped; the pending flag stays 1.
- Latency: pulse in cycle 0 with idle output → evt_valid_o = 1 in cycle 1 (one edge).
- Throughput: one ID per cycle while evt_grant_i = 1 and events are pending.
- pending_o = pending_q (registered; does not include same-cycle events_i).
- Fairness: round-robin guarantees each pending source is emitted within NB_SOURCES transfers.

Optional Feature:
SOC_EVT_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest set index of cand wins; no rr pointer register exists. Starvation of high indices is accepted.
- Undefined (default): round-robin as specified above.

Test Plan:
1. Reset then single pulse events_i[5] in cycle 0, evt_grant_i = 1 → evt_valid_o = 1 and evt_data_o = 8'd5 in cycle 1; evt_valid_o = 0 in cycle 2; pending_o = 0.
2. Backpressure: pulses on sources 3 and 7 together, evt_grant_i = 0 for 4 cycles then 1 → data 3 held stable 4 cycles, then 3 and 7 on consecutive cycles; no overflow.
3. Round-robin: sources 0, 1 and 31 pulsed once, then source 0 pulsed again immediately after its grant → order 0, 1, 31, 0; rr wraps 31→0.
4. Overflow: events_i[2] pulsed in 2 consecutive cycles while evt_grant_i = 0 → err_overflow_o pulses exactly once; only one ID 2 emitted after grant.
5. Simultaneous consume and re-arrive: source 4 pending and selected in the same cycle as a new events_i[4] pulse → two IDs 4 emitted, err_overflow_o stays 0.
6. ID_BASE = 250, EVT_ID_WIDTH = 8, source 10 pulsed → evt_data_o = 8'd4 (wrap). Separately, assert rst_ni low while evt_valid_o = 1 with 3 pending → all outputs 0 immediately, no IDs emitted after release.
